// File: rtl/mdu_if.sv
// Command/result bundle between the E-stage and the multiply/divide controller.
// master = pipeline side, slave = mdu_ctrl.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs, rt, md_use, input busy, stall, hi, lo);
    modport slave  (input start, op, rs, rt, md_use, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, computes results at command acceptance
// and holds them pending for a fixed busy window before committing.
//
// state | meaning
// IDLE  | accepts commands; mthi/mtlo write directly
// BUSY  | fixed-length window running; result committed when cnt hits 1
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic          p_wr_q, p_wr_d;
    logic          busy;

    logic [63:0]   prod_s, prod_u;
    logic          a_neg, b_neg, div_zero;
    logic [31:0]   a_mag, b_mag, b_safe, rt_safe;
    logic [31:0]   q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{bus.rs[31]}}, bus.rs}) * $signed({{32{bus.rt[31]}}, bus.rt});
    assign prod_u = {32'd0, bus.rs} * {32'd0, bus.rt};

    // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign div_zero = (bus.rt == 32'd0);
    assign a_neg    = bus.rs[31];
    assign b_neg    = bus.rt[31];
    assign a_mag    = a_neg ? -bus.rs : bus.rs;
    assign b_mag    = b_neg ? -bus.rt : bus.rt;
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign rt_safe  = div_zero ? 32'd1 : bus.rt;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quo_s    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem_s    = a_neg ? -r_mag : r_mag;
    assign quo_u    = bus.rs / rt_safe;
    assign rem_u    = bus.rs % rt_safe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_wr_q  <= p_wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        p_wr_d  = p_wr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0: begin
                            {p_hi_d, p_lo_d} = prod_s;
                            p_wr_d  = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        3'd1: begin
                            {p_hi_d, p_lo_d} = prod_u;
                            p_wr_d  = 1'b1;
                            cnt_d   = CW'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        3'd2: begin
                            p_hi_d  = rem_s;
                            p_lo_d  = quo_s;
                            p_wr_d  = !div_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        3'd3: begin
                            p_hi_d  = rem_u;
                            p_lo_d  = quo_u;
                            p_wr_d  = !div_zero;
                            cnt_d   = CW'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                        3'd4:    hi_d = bus.rs;
                        3'd5:    lo_d = bus.rs;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (p_wr_q) begin
                        hi_d = p_hi_q;
                        lo_d = p_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == BUSY);
    assign bus.busy  = busy;
    assign bus.stall = bus.md_use & (busy | (bus.start & ~bus.op[2]));
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a reference model pushes expected HI/LO into a
// scoreboard on issue, popped and compared when the busy window closes.
module tb_mdu_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] model_hi, model_lo;
    logic [63:0] sb[$];

    mdu_if bus ();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                               logic [31:0] cur_hi, logic [31:0] cur_lo);
        longint sa, sb_, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        p   = {cur_hi, cur_lo};
        case (op)
            3'd0: p = 64'(sa * sb_);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: if (b != 0) begin
                q = sa / sb_;
                r = sa % sb_;
                p = {r[31:0], q[31:0]};
            end
            3'd3: if (b != 0) p = {a % b, a / b};
            default: ;
        endcase
        return p;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        if (op <= 3'd3) sb.push_back(ref_result(op, a, b, model_hi, model_lo));
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'd7;
    endtask

    task automatic sample(string tag, logic exp_busy, logic exp_stall);
        @(negedge clk);
        chk({tag, "_busy"},  32'(bus.busy),  32'(exp_busy));
        chk({tag, "_stall"}, 32'(bus.stall), 32'(exp_stall));
        chk({tag, "_hi"},    bus.hi, model_hi);
        chk({tag, "_lo"},    bus.lo, model_lo);
    endtask

    task automatic retire(string tag);
        logic [63:0] e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            e = sb.pop_front();
            model_hi = e[63:32];
            model_lo = e[31:0];
        end
    endtask

    task automatic run_op(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                          logic use_md, int n);
        bus.md_use = use_md;
        drive(op, a, b);
        sample({tag, "_c0"}, 1'b0, use_md);
        cycle_end();
        for (int i = 1; i <= n; i++) begin
            sample($sformatf("%s_c%0d", tag, i), 1'b1, use_md);
            cycle_end();
        end
        retire(tag);
        sample({tag, "_done"}, 1'b0, 1'b0);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        checks = 0; failures = 0;
        model_hi = '0; model_lo = '0;
        bus.start = 1'b0; bus.op = 3'd7; bus.rs = '0; bus.rt = '0; bus.md_use = 1'b0;

        sample("reset", 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1, 5);
        cycle_end();
        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);
        cycle_end();
        run_op("div_m7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
        cycle_end();
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10);
        cycle_end();

        // mthi then mtlo on consecutive cycles, md_use held high
        bus.md_use = 1'b1;
        drive(3'd4, 32'h1234_5678, 32'd0);
        sample("mthi_c0", 1'b0, 1'b0);
        cycle_end();
        model_hi = 32'h1234_5678;
        drive(3'd5, 32'h9ABC_DEF0, 32'd0);
        sample("mtlo_c0", 1'b0, 1'b0);
        cycle_end();
        model_lo = 32'h9ABC_DEF0;
        sample("mtlo_c1", 1'b0, 1'b0);
        cycle_end();

        drive(3'd4, 32'hAAAA_0000, 32'd0);
        cycle_end();
        model_hi = 32'hAAAA_0000;
        drive(3'd5, 32'h0000_BBBB, 32'd0);
        cycle_end();
        model_lo = 32'h0000_BBBB;

        // divu by zero, with a stray mult issued in busy cycle 3
        drive(3'd3, 32'h0000_1234, 32'd0);
        sample("divu0_c0", 1'b0, 1'b1);
        cycle_end();
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                bus.start = 1'b1; bus.op = 3'd0; bus.rs = 32'd5; bus.rt = 32'd7;
            end
            sample($sformatf("divu0_c%0d", i), 1'b1, 1'b1);
            cycle_end();
        end
        retire("divu0");
        sample("divu0_done", 1'b0, 1'b0);
        cycle_end();
        sample("divu0_after", 1'b0, 1'b0);
        cycle_end();

        // back-to-back: div issued in the cycle busy drops after a mult
        bus.md_use = 1'b1;
        drive(3'd0, 32'h0001_0000, 32'h0003_0000);
        sample("b2b_mult_c0", 1'b0, 1'b1);
        cycle_end();
        for (int i = 1; i <= 5; i++) begin
            sample($sformatf("b2b_mult_c%0d", i), 1'b1, 1'b1);
            cycle_end();
        end
        retire("b2b_mult");
        drive(3'd2, 32'd100, 32'hFFFF_FFF9);
        sample("b2b_div_c0", 1'b0, 1'b1);
        cycle_end();
        for (int i = 1; i <= 10; i++) begin
            sample($sformatf("b2b_div_c%0d", i), 1'b1, 1'b1);
            cycle_end();
        end
        retire("b2b_div");
        sample("b2b_div_done", 1'b0, 1'b0);
        cycle_end();

        // async reset in busy cycle 2 of a mult
        drive(3'd0, 32'd3, 32'd4);
        sample("rst_mult_c0", 1'b0, 1'b1);
        cycle_end();
        sample("rst_mult_c1", 1'b1, 1'b1);
        cycle_end();
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        chk("async_rst_busy",  32'(bus.busy),  32'd0);
        chk("async_rst_stall", 32'(bus.stall), 32'd0);
        chk("async_rst_hi",    bus.hi, 32'd0);
        chk("async_rst_lo",    bus.lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample($sformatf("post_rst_%0d", i), 1'b0, 1'b0);
            cycle_end();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the pipelined CPU core. It sits beside the E-stage ALU, accepts mult/multu/div/divu/mthi/mtlo commands, and owns the HI/LO registers. It holds a busy window of fixed length per operation and raises a stall request toward the hazard unit while an HI/LO-dependent instruction is in E.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  E-stage command valid this cycle
- op  input  3  command: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 no-op
- rs  input  32  operand A / mthi-mtlo source
- rt  input  32  operand B
- md_use  input  1  E-stage instruction is any HI/LO instruction (mult/div/mfhi/mflo/mthi/mtlo)
- busy  output  1  operation in progress (registered)
- stall  output  1  stall request to hazard unit (combinational)
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- Two states: IDLE, BUSY. Down-counter cnt, width clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- IDLE, start=1, op∈{0..3}: latch computed result into pending registers p_hi/p_lo; load cnt with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); go to BUSY.
- IDLE, start=1, op=4: hi←rs at the edge. op=5: lo←rs. State stays IDLE, busy stays 0.
- IDLE, start=1, op 6/7: ignored.
- BUSY: cnt decrements each edge. At the edge where cnt=1: hi←p_hi, lo←p_lo, go to IDLE.
- start sampled while BUSY is ignored. The hazard unit freezes upstream, so a legal stream never does this. The bench checks hi/lo are unaffected.
- stall = md_use & (busy | (start & op≤3)).
- Arithmetic:
  - mult: {hi,lo} = signed 64-bit rs×rt.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Boundary cases:
  - Divide by zero (rt=0, op 2/3): full busy window runs; hi/lo unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset asserted at any time, including mid-BUSY: state IDLE, cnt=0, busy=0, hi=0, lo=0, pending result discarded. stall follows its combinational equation, so it is 0 unless start&md_use.

## Timing
- Reset values: busy=0, hi=0, lo=0; stall=0 while start=0.
- Command accepted at edge E0 (start=1 in cycle 0). busy=1 in cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
- New hi/lo values become visible in cycle N+1, the same cycle busy returns to 0.
- stall is 1 in cycle 0 if md_use, and in cycles 1..N whenever md_use=1.
- An mfhi/mflo in cycle N+1 reads the new value with no stall.
- Back-to-back: a new start in cycle N+1 is accepted (IDLE). mthi/mtlo update hi/lo at the next edge, with 1-cycle latency and no busy.
- No combinational path from rs/rt to hi/lo, busy or stall.

## Test plan
- Reset, then mult rs=0xFFFFFFFE (−2), rt=3: busy high in cycles 1–5, stall high in cycles 0–5 with md_use=1, then hi=0xFFFFFFFF, lo=0xFFFFFFFA in cycle 6.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF: after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001. div rs=−7 (0xFFFFFFF9), rt=2: busy cycles 1–10, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- mthi rs=0x12345678 then mtlo rs=0x9ABCDEF0 on consecutive cycles: hi and lo each update one edge later; busy and stall stay 0 throughout.
- divu rt=0 after hi/lo preloaded with 0xAAAA0000/0x0000BBBB: busy runs 10 cycles; hi/lo unchanged afterwards. Start op=0 issued in busy cycle 3: ignored, hi/lo unchanged.
- mult begins; assert reset asynchronously (between edges) during busy cycle 2: busy, hi and lo go to 0 immediately without a clock edge; no write occurs after reset is released.
- Back-to-back: mult then div issued in cycle 6 right after busy drops: div is accepted, busy stays continuously high from cycle 7 to cycle 16, and the final hi/lo equal the div result.
